// File: rtl/fx_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fx_alu_pkg
//  Description : Shared types and constants for the sequential fixed-point
//                ALU. Provides the opcode and FSM state enums, plus helper
//                functions that give the saturation extremes for an N-bit
//                two's-complement word.
//  Contents    : op_e     - operation code carried on the operand bus
//                state_e  - controller state encoding
//                max_pos  - 2^(N-1)-1, zero-extended to FX_MAX_N bits
//                min_neg  - bit pattern of -2^(N-1), zero-extended
//  Revision    : 1.0 - initial release
// ============================================================================
package fx_alu_pkg;

  // Widest word the helper functions can describe. The ALU width N must not
  // exceed this value.
  localparam int FX_MAX_N = 64;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    MUL1 = 3'd2,
    DIV  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Largest positive value of an n-bit signed word.
  function automatic logic [FX_MAX_N-1:0] max_pos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Most negative value of an n-bit signed word. The same pattern read as
  // unsigned is the magnitude 2^(n-1).
  function automatic logic [FX_MAX_N-1:0] min_neg(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fx_alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : fx_alu_seq_if
//  Description : Operand and result handshake bundle of the fixed-point ALU.
//  Signals     : in_valid/in_ready  - operand transfer handshake
//                a, b, op           - signed operands and operation code
//                out_valid/out_ready- result transfer handshake
//                result             - signed result
//                overflow           - true result not representable
//                div_by_zero        - DIV issued with b == 0
//  Modports    : master - producer of operands / consumer of results
//                slave  - the ALU itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface fx_alu_seq_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         overflow;
  logic         div_by_zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, overflow, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/fx_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : fx_div_iter
//  Description : Unsigned restoring divider, one quotient bit per clock.
//                Produces an (N+FRAC)-bit quotient after N+FRAC iterations.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                start                - load operands, begin iterating
//                dividend [N+FRAC]    - unsigned dividend
//                divisor  [N]         - unsigned, non-zero divisor
//                busy                 - iterations in progress
//                done                 - one-cycle pulse, quotient valid
//                quotient [N+FRAC]    - unsigned quotient (held until start)
//  Revision    : 1.0 - initial release
// ============================================================================
module fx_div_iter #(
  parameter int N    = 32,
  parameter int FRAC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N+FRAC-1:0] dividend,
  input  logic [N-1:0]      divisor,
  output logic              busy,
  output logic              done,
  output logic [N+FRAC-1:0] quotient
);
  localparam int W  = N + FRAC;
  localparam int CW = $clog2(W + 1);

  logic [N-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N:0]    shifted;
  logic [N:0]    trial;

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    // The partial remainder stays below the divisor, so the shifted value
    // needs one extra bit and the trial difference fits back into N bits.
    shifted = {rem_q, quo_q[W-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = CW'(W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!trial[N]) begin
        rem_d = trial[N-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted[N-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;
endmodule
`default_nettype wire

// File: rtl/fx_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fx_alu_seq
//  Description : Sequential signed Q(N-FRAC).FRAC ALU (ADD/SUB/MUL/DIV) with
//                valid/ready handshakes, optional saturation and status flags.
//                Single-issue: one operation in flight at a time.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - fx_alu_seq_if.slave (operands in, result out)
//  Revision    : 1.0 - initial release
// ============================================================================
module fx_alu_seq
  import fx_alu_pkg::*;
#(
  parameter int N    = 32,
  parameter int FRAC = 16,
  parameter bit SAT  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  fx_alu_seq_if.slave bus
);
  localparam logic [N-1:0] MAX_POS = N'(max_pos(N));
  localparam logic [N-1:0] MIN_NEG = N'(min_neg(N));
  localparam int           W       = N + FRAC;

  state_e       state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  op_e          op_q, op_d;
  logic [N-1:0] result_q, result_d;
  logic         overflow_q, overflow_d;
  logic         dbz_q, dbz_d;
  logic         in_ready_q, in_ready_d;

  logic         accept;
  logic [N-1:0] in_mag_a, in_mag_b;
  logic         div_start, div_busy, div_done;
  logic [W-1:0] div_quo;

  logic [N:0]     sum_ext;
  logic           sum_ovf;
  logic [N-1:0]   add_result;
  logic [N-1:0]   mag_a_q, mag_b_q;
  logic [2*N-1:0] prod, mag_sel;
  logic           sign_q, mag_ovf;
  logic [N-1:0]   mag_low, mag_result;

  assign accept   = bus.in_valid && in_ready_q;
  // Magnitude of -2^(N-1) wraps to the same pattern, which read as unsigned
  // is exactly 2^(N-1).
  assign in_mag_a = bus.a[N-1] ? -bus.a : bus.a;
  assign in_mag_b = bus.b[N-1] ? -bus.b : bus.b;
  // The divider loads straight from the bus on the accept edge so its
  // iterations line up with the DIV state; a zero divisor never starts it.
  assign div_start = accept && (op_e'(bus.op) == OP_DIV) && (bus.b != '0) && !div_busy;

  fx_div_iter #(
    .N    (N),
    .FRAC (FRAC)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend ({in_mag_a, {FRAC{1'b0}}}),
    .divisor  (in_mag_b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Datapath for the captured operands.
  always_comb begin
    if (op_q == OP_SUB) sum_ext = {a_q[N-1], a_q} - {b_q[N-1], b_q};
    else                sum_ext = {a_q[N-1], a_q} + {b_q[N-1], b_q};
    sum_ovf = sum_ext[N] ^ sum_ext[N-1];
    if (sum_ovf && SAT) add_result = sum_ext[N] ? MIN_NEG : MAX_POS;
    else                add_result = sum_ext[N-1:0];

    mag_a_q = a_q[N-1] ? -a_q : a_q;
    mag_b_q = b_q[N-1] ? -b_q : b_q;
    prod    = {{N{1'b0}}, mag_a_q} * {{N{1'b0}}, mag_b_q};
    sign_q  = a_q[N-1] ^ b_q[N-1];
    // MUL and DIV share the sign/overflow/saturation stage on a magnitude.
    mag_sel = (state_q == DIV) ? {{(N-FRAC){1'b0}}, div_quo} : (prod >> FRAC);
    mag_ovf = sign_q ? (mag_sel > {{N{1'b0}}, MIN_NEG})
                     : (mag_sel > {{N{1'b0}}, MAX_POS});
    mag_low = mag_sel[N-1:0];
    if (mag_ovf && SAT) mag_result = sign_q ? MIN_NEG : MAX_POS;
    else                mag_result = sign_q ? -mag_low : mag_low;
  end

  // Controller: next state and result register updates.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    dbz_d      = dbz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d  = bus.a;
          b_d  = bus.b;
          op_d = op_e'(bus.op);
          case (op_e'(bus.op))
            OP_MUL:  state_d = MUL1;
            OP_DIV:  state_d = DIV;
            default: state_d = EXEC;
          endcase
        end
      end
      EXEC: begin
        result_d   = add_result;
        overflow_d = sum_ovf;
        dbz_d      = 1'b0;
        state_d    = DONE;
      end
      MUL1: begin
        result_d   = mag_result;
        overflow_d = mag_ovf;
        dbz_d      = 1'b0;
        state_d    = DONE;
      end
      DIV: begin
        if (b_q == '0) begin
          result_d   = a_q[N-1] ? MIN_NEG : MAX_POS;
          overflow_d = 1'b1;
          dbz_d      = 1'b1;
          state_d    = DONE;
        end else if (div_done) begin
          result_d   = mag_result;
          overflow_d = mag_ovf;
          dbz_d      = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered so in_ready is low throughout reset and rises on the first
    // edge after release.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      result_q   <= '0;
      overflow_q <= 1'b0;
      dbz_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      dbz_q      <= dbz_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.result      = result_q;
  assign bus.overflow    = overflow_q;
  assign bus.div_by_zero = dbz_q;
endmodule
`default_nettype wire

// File: tb/tb_fx_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fx_alu_seq
//  Description : Self-checking bench for fx_alu_seq. Two instances (SAT=1 and
//                SAT=0) receive identical stimulus; expected results from a
//                64-bit arithmetic model are queued at accept time and checked
//                when each instance hands its result over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fx_alu_seq;
  localparam int N    = 32;
  localparam int FRAC = 16;
  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fx_alu_seq_if #(.N(N)) bus1 ();
  fx_alu_seq_if #(.N(N)) bus0 ();

  fx_alu_seq #(.N(N), .FRAC(FRAC), .SAT(1'b1)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  fx_alu_seq #(.N(N), .FRAC(FRAC), .SAT(1'b0)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  int   n_vec = 0;
  int   n_miss = 0;
  exp_t sbq1[$];
  exp_t sbq0[$];
  int   first_c[2] = '{-1, -1};
  bit   rdy_chk[2] = '{1'b0, 1'b0};
  int   last_acc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference arithmetic on full-precision signed integers.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input bit sat);
    exp_t   e;
    longint sa, sb, t;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    e.dbz = 1'b0;
    e.lat = 2;
    e.acc = 0;
    t     = 0;
    case (op)
      2'd0: t = sa + sb;
      2'd1: t = sa - sb;
      2'd2: t = (sa * sb) / 65536;
      default: begin
        if (sb == 0) begin
          e.dbz = 1'b1;
          e.ovf = 1'b1;
          e.res = (sa >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
          return e;
        end
        t     = (sa * 65536) / sb;
        e.lat = N + FRAC + 2;
      end
    endcase
    e.ovf = (t > MAXP) || (t < MINN);
    if (e.ovf && sat) e.res = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    else              e.res = t[31:0];
    return e;
  endfunction

  task automatic mon_step(input int w, input logic ov, input logic rdy, input logic ir,
                          input logic [31:0] res, input logic ovf, input logic dbz);
    exp_t  e;
    string s;
    s = (w == 1) ? "sat" : "wrap";
    if (ov) begin
      if (first_c[w] < 0) first_c[w] = cyc;
      if ((w == 1 && sbq1.size() == 0) || (w == 0 && sbq0.size() == 0)) begin
        check_eq({s, "_spurious_out_valid"}, 64'(ov), 64'd0);
      end else begin
        e = (w == 1) ? sbq1[0] : sbq0[0];
        if (rdy) begin
          if (w == 1) void'(sbq1.pop_front());
          else        void'(sbq0.pop_front());
          check_eq({s, "_result"},      64'(res), 64'(e.res));
          check_eq({s, "_overflow"},    64'(ovf), 64'(e.ovf));
          check_eq({s, "_div_by_zero"}, 64'(dbz), 64'(e.dbz));
          check_eq({s, "_latency"},     64'(first_c[w] + 1 - e.acc), 64'(e.lat));
          first_c[w] = -1;
          rdy_chk[w] = 1'b1;
        end else begin
          check_eq({s, "_hold_result"},   64'(res), 64'(e.res));
          check_eq({s, "_hold_in_ready"}, 64'(ir),  64'd0);
        end
      end
    end else if (rdy_chk[w]) begin
      check_eq({s, "_in_ready_after_take"}, 64'(ir), 64'd1);
      rdy_chk[w] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      first_c = '{-1, -1};
      rdy_chk = '{1'b0, 1'b0};
    end else begin
      mon_step(1, bus1.out_valid, bus1.out_ready, bus1.in_ready,
               bus1.result, bus1.overflow, bus1.div_by_zero);
      mon_step(0, bus0.out_valid, bus0.out_ready, bus0.in_ready,
               bus0.result, bus0.overflow, bus0.div_by_zero);
    end
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op);
    bus1.in_valid = v; bus1.a = a; bus1.b = b; bus1.op = op;
    bus0.in_valid = v; bus0.a = a; bus0.b = b; bus0.op = op;
  endtask

  task automatic set_ready(input logic r);
    bus1.out_ready = r;
    bus0.out_ready = r;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    exp_t e1, e0;
    bit   got;
    got = 1'b0;
    drive(1'b1, a, b, op);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus1.in_ready && bus0.in_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      check_eq("accept_timeout", 64'd0, 64'd1);
      drive(1'b0, 32'd0, 32'd0, 2'd0);
      return;
    end
    e1 = model(a, b, op, 1'b1);
    e0 = model(a, b, op, 1'b0);
    e1.acc = cyc + 1;
    e0.acc = cyc + 1;
    last_acc = cyc + 1;
    sbq1.push_back(e1);
    sbq0.push_back(e0);
    @(posedge clk); #1;
    // Scramble the bus so any late sampling of operands shows up.
    drive(1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (sbq1.size() == 0 && sbq0.size() == 0) break;
      @(negedge clk);
    end
    if (sbq1.size() != 0 || sbq0.size() != 0) begin
      check_eq("drain_timeout", 64'(sbq1.size() + sbq0.size()), 64'd0);
      sbq1.delete();
      sbq0.delete();
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
      2:       return 32'd0;
      3:       return ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      default: return 32'($urandom_range(0, 32'h0000_4000)) - 32'h0000_2000;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_a, acc_b, acc_c;
    drive(1'b0, 32'd0, 32'd0, 2'd0);
    set_ready(1'b1);
    rst_n = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready",    64'(bus1.in_ready),    64'd0);
    check_eq("rst_out_valid",   64'(bus1.out_valid),   64'd0);
    check_eq("rst_result",      64'(bus1.result),      64'd0);
    check_eq("rst_overflow",    64'(bus1.overflow),    64'd0);
    check_eq("rst_div_by_zero", 64'(bus1.div_by_zero), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("in_ready_after_release", 64'(bus1.in_ready), 64'd1);
    @(posedge clk); #1;

    // MUL.
    send(32'h0003_0000, 32'h0002_0000, 2'd2);
    send(32'hFFFF_8000, 32'h0003_0000, 2'd2);
    wait_drain();

    // DIV with full iteration latency.
    send(32'hFFFE_8000, 32'h0000_8000, 2'd3);
    wait_drain();

    // ADD overflow: saturated on one instance, wrapped on the other.
    send(32'h7FFF_0000, 32'h0001_0000, 2'd0);
    wait_drain();

    // Division by zero, both signs.
    send(32'h0001_0000, 32'h0000_0000, 2'd3);
    send(32'hFFFF_0000, 32'h0000_0000, 2'd3);
    wait_drain();

    // Back-to-back ADDs: one accept every three cycles.
    send(32'h0001_0000, 32'h0001_0000, 2'd0);
    acc_a = last_acc;
    send(32'h0002_0000, 32'hFFFF_0000, 2'd0);
    acc_b = last_acc;
    send(32'h8000_0000, 32'hFFFF_FFFF, 2'd0);
    acc_c = last_acc;
    check_eq("throughput_1", 64'(acc_b - acc_a), 64'd3);
    check_eq("throughput_2", 64'(acc_c - acc_b), 64'd3);
    wait_drain();

    // Backpressure on a SUB: result and in_ready held while stalled.
    set_ready(1'b0);
    send(32'h0005_0000, 32'h0007_0000, 2'd1);
    repeat (11) @(posedge clk);
    #1;
    set_ready(1'b1);
    wait_drain();

    // Mixed random operations.
    for (int i = 0; i < 20; i++) begin
      send(pick(), pick(), 2'($urandom_range(0, 3)));
    end
    wait_drain();

    // Leave a non-zero result in the output registers, then reset mid-DIV.
    send(32'h0003_0000, 32'h0004_0000, 2'd0);
    wait_drain();
    send(32'h0007_0000, 32'h0002_0000, 2'd3);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sbq1.delete();
    sbq0.delete();
    @(negedge clk);
    check_eq("midrst_out_valid",   64'(bus1.out_valid),   64'd0);
    check_eq("midrst_result",      64'(bus1.result),      64'd0);
    check_eq("midrst_overflow",    64'(bus1.overflow),    64'd0);
    check_eq("midrst_div_by_zero", 64'(bus1.div_by_zero), 64'd0);
    check_eq("midrst_in_ready",    64'(bus1.in_ready),    64'd0);
    check_eq("midrst_wrap_result", 64'(bus0.result),      64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Any leftover result would appear as a spurious out_valid here.
    repeat (60) @(posedge clk);
    #1;
    send(32'h0001_0000, 32'h0001_0000, 2'd0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fx_alu_seq.md
# fx_alu_seq

Sequential, parametrised signed fixed-point ALU executing ADD, SUB, MUL and DIV on two's-complement Q(N-FRAC).FRAC operands. Operands enter through a valid/ready handshake, and results leave through a second one. Optional saturation and status flags are provided. The block sits between the physics integrator's operand scheduler and its state-register writeback. It replaces the combinational ALU: the multiplier is registered, and division is iterative at one quotient bit per cycle.

## Interface
- N, 32, total operand/result width in bits (≥ 8).
- FRAC, 16, fractional bits (1 ≤ FRAC < N).
- SAT, 1, 1 = clamp out-of-range results to the representable extreme; 0 = wrap (low N bits).

- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept an operand bundle.
- a  in  N  signed operand A.
- b  in  N  signed operand B.
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts the result.
- result  out  N  signed result.
- overflow  out  1  true result was outside [-2^(N-1), 2^(N-1)-1] × 2^-FRAC.
- div_by_zero  out  1  DIV with b == 0.

## Operation
- Single-issue: at most one operation is in flight. Transfers occur on edges where valid && ready.
- FSM states:
  - IDLE: in_ready=1. Accept goes to EXEC for ADD/SUB, MUL1 for MUL, DIV for DIV.
  - EXEC: compute; next state DONE.
  - MUL1: register |a|·|b| (2N bits); next state DONE.
  - DIV: one restoring iteration per cycle, N+FRAC iterations; then DONE.
  - DONE: out_valid=1; hold all outputs stable until out_ready, then go to IDLE.
- Operands and op are captured on accept; later input changes have no effect.
- ADD/SUB: computed at N+1 bits. Overflow when bits N and N-1 differ.
- MUL: uses magnitudes (|−2^(N-1)| = 2^(N-1) as an N-bit unsigned value). The product is shifted right by FRAC, so it truncates toward zero. The sign of the result is a[N-1]^b[N-1]. Overflow when the magnitude exceeds 2^(N-1)-1 for a positive result, or 2^(N-1) for a negative result.
- DIV: the dividend is |a|<<FRAC at N+FRAC bits and the divisor is |b|. The quotient truncates toward zero, and the result sign is a[N-1]^b[N-1]. Overflow uses the same magnitude rule as MUL.
- DIV with b == 0: skips the iterations and goes from DIV straight to DONE on the next cycle. div_by_zero=1 and overflow=1. Result is 2^(N-1)-1 if a ≥ 0, else -2^(N-1), regardless of SAT.
- Overflow result:
  - SAT=1: result = 2^(N-1)-1 if the true result is positive, else -2^(N-1).
  - SAT=0: result = low N bits of the signed true result.
- Flags are meaningful only while out_valid=1. They are 0 for non-overflowing operations.

## Timing
- Reset values: in_ready=0 during reset and 1 on the first cycle after release. out_valid=0, result=0, overflow=0, div_by_zero=0. FSM is in IDLE.
- Latency, measured from the accept edge t to the first edge at which out_valid is sampled high:
  - ADD/SUB: t+2.
  - MUL: t+2.
  - DIV: t+N+FRAC+2.
  - DIV with b=0: t+2.
- in_ready=0 in every state except IDLE. A new operation cannot be accepted in the same cycle a result is taken; the earliest next accept is the cycle after the out_ready handshake.
- Back-to-back throughput with out_ready held high: one ADD every 3 cycles.
- rst_n asserted in any state returns immediately to reset values. Any in-flight operation is discarded and no result is produced.

## Structure
- fx_alu_pkg holds:
  - op_e enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - state_e enum: IDLE, EXEC, MUL1, DIV, DONE.
  - Constants MAX_POS and MIN_NEG as functions of N.
- Sub-module fx_div_iter is the restoring divider. It uses start/busy/done, parameters N and FRAC, and takes magnitudes in and gives an unsigned quotient out. The top level handles signs, saturation and the handshake.

## Test plan
N=32, FRAC=16, SAT=1 unless noted.
- MUL 0x0003_0000 × 0x0002_0000 → 0x0006_0000 at t+2. MUL 0xFFFF_8000 (−0.5) × 0x0003_0000 → 0xFFFE_8000 (−1.5). overflow=0.
- DIV 0xFFFE_8000 (−1.5) ÷ 0x0000_8000 (0.5) → 0xFFFD_0000 (−3.0), with out_valid first high at t+50.
- ADD 0x7FFF_0000 + 0x0001_0000 → 0x7FFF_FFFF with overflow=1. With SAT=0 → 0x8000_0000 with overflow=1.
- DIV 0x0001_0000 ÷ 0 → 0x7FFF_FFFF, div_by_zero=1, at t+2. DIV 0xFFFF_0000 ÷ 0 → 0x8000_0000.
- Backpressure: hold out_ready=0 for 10 cycles after a SUB of 5.0 − 7.0. result stays 0xFFFE_0000 and in_ready stays 0 throughout. The handshake completes once, and in_ready=1 on the next cycle.
- Assert rst_n=0 at iteration 20 of a DIV. out_valid stays 0 and outputs go to reset values. After release, ADD 1.0 + 1.0 → 0x0002_0000.
